// File: rtl/ysyx_22041412_pipe_pkg.sv
// Shared constants and helpers for the pipeline hazard controller.
package ysyx_22041412_pipe_pkg;

    // Default number of tracked stages after ID (EX .. WB).
    localparam int unsigned DEPTH_DEF = 3;

    // Forwarding select value meaning "take the register file".
    localparam int unsigned FWD_RF = 0;

    // Stage index of EX; WB is the last tracked stage, see wb_stage().
    localparam int unsigned EX = 0;

    function automatic int unsigned wb_stage(input int unsigned depth);
        return depth - 1;
    endfunction

    // One forwarding select encodes register file plus one source per stage.
    function automatic int unsigned sel_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/ysyx_22041412_hazard_ctrl_if.sv
// Decode/pipeline side bundle of the hazard controller.
// master: pipeline (drives ID info and busy/redirect), slave: hazard controller.
interface ysyx_22041412_hazard_ctrl_if #(
    parameter int unsigned NREG  = 32,
    parameter int unsigned NRP   = 2,
    parameter int unsigned DEPTH = ysyx_22041412_pipe_pkg::DEPTH_DEF
);
    localparam int unsigned AW   = $clog2(NREG);
    localparam int unsigned SELW = ysyx_22041412_pipe_pkg::sel_width(DEPTH);

    logic                  id_valid;
    logic [NRP*AW-1:0]     id_rs;
    logic [NRP-1:0]        id_rs_used;
    logic [AW-1:0]         id_rd;
    logic                  id_rd_wen;
    logic                  id_is_load;
    logic                  ex_busy;
    logic                  mem_busy;
    logic                  redirect;

    logic                  if_en;
    logic                  id_en;
    logic                  flush_id;
    logic                  bubble_ex;
    logic [DEPTH-1:0]      stage_en;
    logic [NRP*SELW-1:0]   fwd_sel;
    logic [DEPTH-1:0]      stage_valid;

    modport master (
        output id_valid, id_rs, id_rs_used, id_rd, id_rd_wen, id_is_load,
        output ex_busy, mem_busy, redirect,
        input  if_en, id_en, flush_id, bubble_ex, stage_en, fwd_sel, stage_valid
    );

    modport slave (
        input  id_valid, id_rs, id_rs_used, id_rd, id_rd_wen, id_is_load,
        input  ex_busy, mem_busy, redirect,
        output if_en, id_en, flush_id, bubble_ex, stage_en, fwd_sel, stage_valid
    );

endinterface

// File: rtl/ysyx_22041412_raw_match.sv
// Priority RAW match of one decode read port against all tracked stages.
// The youngest (lowest index) matching stage wins.
module ysyx_22041412_raw_match #(
    parameter int unsigned AW    = 5,
    parameter int unsigned DEPTH = 3,
    parameter int unsigned SELW  = 2
) (
    input  logic [AW-1:0]            rs,
    input  logic                     rs_used,
    input  logic [DEPTH-1:0]         v,
    input  logic [DEPTH-1:0]         wen,
    input  logic [DEPTH-1:0]         ld,
    input  logic [DEPTH-1:0][AW-1:0] rd,
    output logic                     hit,
    output logic [SELW-1:0]          idx,
    output logic                     is_load
);

    // Scan oldest to youngest so the youngest match overwrites older ones.
    always_comb begin
        hit     = 1'b0;
        idx     = '0;
        is_load = 1'b0;
        if (rs_used && (rs != '0)) begin
            for (int s = int'(DEPTH) - 1; s >= 0; s--) begin
                if (v[s] && wen[s] && (rd[s] == rs)) begin
                    hit     = 1'b1;
                    idx     = SELW'(s);
                    is_load = ld[s];
                end
            end
        end
    end

endmodule

// File: rtl/ysyx_22041412_hazard_ctrl.sv
// Pipeline hazard controller: tracks destination registers of in-flight
// instructions after ID, produces stage enables, bubble/flush strobes and
// per-port forwarding selects.
// Optional feature macro: YSYX_22041412_FWD_EN (operand forwarding). Without
// it every RAW match in a tracked stage stalls ID and fwd_sel stays 0.
module ysyx_22041412_hazard_ctrl
    import ysyx_22041412_pipe_pkg::*;
#(
    parameter int unsigned NREG     = 32,
    parameter int unsigned NRP      = 2,
    parameter int unsigned DEPTH    = DEPTH_DEF,
    parameter int unsigned LD_STAGE = 1
) (
    input logic                     clk,
    input logic                     rst,
    ysyx_22041412_hazard_ctrl_if.slave bus
);

    localparam int unsigned AW   = $clog2(NREG);
    localparam int unsigned SELW = sel_width(DEPTH);

    logic [DEPTH-1:0]         v_q, wen_q, ld_q;
    logic [DEPTH-1:0]         v_d, wen_d, ld_d;
    logic [DEPTH-1:0][AW-1:0] rd_q, rd_d;

    logic                     frz;
    logic [SELW-1:0]          frz_stg;

    logic [NRP-1:0]           m_hit, m_ld, hz_p;
    logic [NRP-1:0][SELW-1:0] m_idx, fwd_raw;
    logic                     id_hazard;

    logic                     if_en, id_en, flush_id, bubble_ex;
    logic [DEPTH-1:0]         stage_en;
    logic [NRP*SELW-1:0]      fwd_sel;

    // Freeze point: highest stalled stage; memory wait dominates EX busy.
    always_comb begin
        frz     = bus.mem_busy | bus.ex_busy;
        frz_stg = bus.mem_busy ? SELW'(LD_STAGE) : SELW'(EX);
    end

    for (genvar p = 0; p < NRP; p++) begin : g_port
        ysyx_22041412_raw_match #(
            .AW    (AW),
            .DEPTH (DEPTH),
            .SELW  (SELW)
        ) u_match (
            .rs      (bus.id_rs[p*AW +: AW]),
            .rs_used (bus.id_rs_used[p]),
            .v       (v_q),
            .wen     (wen_q),
            .ld      (ld_q),
            .rd      (rd_q),
            .hit     (m_hit[p]),
            .idx     (m_idx[p]),
            .is_load (m_ld[p])
        );
    end

`ifdef YSYX_22041412_FWD_EN
    // Forward from the youngest producer unless its load data is not ready yet.
    always_comb begin
        for (int p = 0; p < NRP; p++) begin
            hz_p[p]    = m_hit[p] && m_ld[p] && (m_idx[p] < SELW'(LD_STAGE));
            fwd_raw[p] = (m_hit[p] && !hz_p[p]) ? m_idx[p] + 1'b1 : SELW'(FWD_RF);
        end
    end
`else
    // No bypass network and no write-through regfile: any match must drain.
    always_comb begin
        for (int p = 0; p < NRP; p++) begin
            hz_p[p]    = m_hit[p];
            fwd_raw[p] = SELW'(FWD_RF);
        end
    end

    logic unused_match;
    assign unused_match = ^{m_idx, m_ld};
`endif

    assign id_hazard = bus.id_valid & (|hz_p);

    // Control outputs; freeze beats redirect, redirect beats load-use.
    always_comb begin
        if_en     = 1'b1;
        id_en     = 1'b1;
        flush_id  = 1'b0;
        bubble_ex = 1'b0;
        stage_en  = '1;
        fwd_sel   = '0;
        if (rst) begin
            flush_id  = 1'b1;
            bubble_ex = 1'b1;
        end else begin
            if (bus.id_valid) begin
                for (int p = 0; p < NRP; p++) begin
                    fwd_sel[p*SELW +: SELW] = fwd_raw[p];
                end
            end
            if (frz) begin
                if_en = 1'b0;
                id_en = 1'b0;
                for (int s = 0; s < DEPTH; s++) begin
                    if (SELW'(s) <= frz_stg) begin
                        stage_en[s] = 1'b0;
                    end
                end
            end else if (bus.redirect) begin
                flush_id  = 1'b1;
                bubble_ex = 1'b1;
            end else if (id_hazard) begin
                if_en     = 1'b0;
                id_en     = 1'b0;
                bubble_ex = 1'b1;
            end
        end
    end

    // Tracking shift: a stage whose predecessor holds receives a bubble.
    always_comb begin
        v_d   = v_q;
        rd_d  = rd_q;
        wen_d = wen_q;
        ld_d  = ld_q;
        if (stage_en[EX]) begin
            v_d[EX]   = bus.id_valid & ~bubble_ex;
            rd_d[EX]  = bus.id_rd;
            wen_d[EX] = bus.id_rd_wen;
            ld_d[EX]  = bus.id_is_load;
        end
        for (int s = 1; s < DEPTH; s++) begin
            if (stage_en[s]) begin
                v_d[s]   = v_q[s-1] & stage_en[s-1];
                rd_d[s]  = rd_q[s-1];
                wen_d[s] = wen_q[s-1];
                ld_d[s]  = ld_q[s-1];
            end
        end
    end

    // Tracking registers; reset clears valid bits regardless of busy inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_q <= '0;
        end else begin
            v_q <= v_d;
        end
        rd_q  <= rd_d;
        wen_q <= wen_d;
        ld_q  <= ld_d;
    end

    assign bus.if_en       = if_en;
    assign bus.id_en       = id_en;
    assign bus.flush_id    = flush_id;
    assign bus.bubble_ex   = bubble_ex;
    assign bus.stage_en    = stage_en;
    assign bus.fwd_sel     = fwd_sel;
    assign bus.stage_valid = v_q;

endmodule

// File: tb/tb_ysyx_22041412_hazard_ctrl.sv
// Self-checking bench for ysyx_22041412_hazard_ctrl: directed scenarios with
// literal expectations, then random stimulus against a pipeline model.
module tb_ysyx_22041412_hazard_ctrl;

    localparam int NREG     = 32;
    localparam int NRP      = 2;
    localparam int DEPTH    = 3;
    localparam int LD_STAGE = 1;
    localparam int AW       = 5;
    localparam int SELW     = 2;

    typedef struct packed {
        logic          v;
        logic [AW-1:0] rd;
        logic          wen;
        logic          ld;
    } ent_t;

    logic clk;
    logic rst;
    bit   chk_en;
    int   n_cmp;
    int   n_err;
    ent_t m     [DEPTH];
    ent_t m_nxt [DEPTH];

    ysyx_22041412_hazard_ctrl_if #(.NREG(NREG), .NRP(NRP), .DEPTH(DEPTH)) bus ();

    ysyx_22041412_hazard_ctrl #(
        .NREG     (NREG),
        .NRP      (NRP),
        .DEPTH    (DEPTH),
        .LD_STAGE (LD_STAGE)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: each stage holds an instruction record; outputs follow from the
    // freeze point and the youngest matching producer of each source.
    always @(negedge clk) begin
        int f, y;
        logic [AW-1:0] r;
        bit hz;
        logic [NRP*SELW-1:0] e_fs;
        bit e_if, e_id, e_fl, e_bx;
        logic [DEPTH-1:0] e_se, e_sv;
        if (chk_en) begin
            f = bus.mem_busy ? LD_STAGE : (bus.ex_busy ? 0 : -1);
            hz = 0;
            e_fs = '0;
            for (int p = 0; p < NRP; p++) begin
                r = bus.id_rs[p*AW +: AW];
                if (bus.id_valid && bus.id_rs_used[p] && r != 0) begin
                    y = -1;
                    for (int s = 0; s < DEPTH; s++)
                        if (y < 0 && m[s].v && m[s].wen && m[s].rd == r) y = s;
                    if (y >= 0) begin
`ifdef YSYX_22041412_FWD_EN
                        if (m[y].ld && y < LD_STAGE) hz = 1;
                        else e_fs[p*SELW +: SELW] = SELW'(y + 1);
`else
                        hz = 1;
`endif
                    end
                end
            end
            e_se = '1;
            if (rst) begin
                e_if = 1; e_id = 1; e_fl = 1; e_bx = 1; e_fs = '0;
            end else if (f >= 0) begin
                e_if = 0; e_id = 0; e_fl = 0; e_bx = 0;
                for (int s = 0; s < DEPTH; s++) e_se[s] = (s > f);
            end else if (bus.redirect) begin
                e_if = 1; e_id = 1; e_fl = 1; e_bx = 1;
            end else if (hz) begin
                e_if = 0; e_id = 0; e_fl = 0; e_bx = 1;
            end else begin
                e_if = 1; e_id = 1; e_fl = 0; e_bx = 0;
            end
            for (int s = 0; s < DEPTH; s++) e_sv[s] = m[s].v;

            chk("cyc_if_en", bus.if_en, e_if);
            chk("cyc_id_en", bus.id_en, e_id);
            chk("cyc_flush_id", bus.flush_id, e_fl);
            chk("cyc_bubble_ex", bus.bubble_ex, e_bx);
            chk("cyc_stage_en", bus.stage_en, e_se);
            chk("cyc_fwd_sel", bus.fwd_sel, e_fs);
            chk("cyc_stage_valid", bus.stage_valid, e_sv);

            for (int s = 0; s < DEPTH; s++) begin
                if (rst) m_nxt[s] = '0;
                else if (f >= 0 && s <= f) m_nxt[s] = m[s];
                else if (f >= 0 && s == f + 1) m_nxt[s] = '0;
                else if (s == 0)
                    m_nxt[s] = e_bx ? '0 : {bus.id_valid, bus.id_rd, bus.id_rd_wen, bus.id_is_load};
                else m_nxt[s] = m[s-1];
            end
        end
    end

    always @(posedge clk) begin
        if (chk_en) begin
            for (int s = 0; s < DEPTH; s++) m[s] = m_nxt[s];
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        bus.id_valid = 0; bus.id_rs = '0; bus.id_rs_used = '0; bus.id_rd = '0;
        bus.id_rd_wen = 0; bus.id_is_load = 0; bus.ex_busy = 0; bus.mem_busy = 0;
        bus.redirect = 0;
    endtask

    task automatic issue(input int rd, input bit ld);
        quiet();
        bus.id_valid = 1; bus.id_rd = AW'(rd); bus.id_rd_wen = 1; bus.id_is_load = ld;
    endtask

    task automatic reader(input int port, input int rs);
        quiet();
        bus.id_valid = 1;
        bus.id_rs_used[port] = 1'b1;
        bus.id_rs[port*AW +: AW] = AW'(rs);
    endtask

    task automatic drain();
        quiet();
        repeat (4) step();
    endtask

    initial begin
        for (int s = 0; s < DEPTH; s++) begin m[s] = '0; m_nxt[s] = '0; end
        n_cmp = 0; n_err = 0; chk_en = 0;
        rst = 1;
        quiet();
        step();
        chk_en = 1;
        #2;
        chk("rst_flush_id", bus.flush_id, 1'b1);
        chk("rst_bubble_ex", bus.bubble_ex, 1'b1);
        chk("rst_if_en", bus.if_en, 1'b1);
        chk("rst_stage_en", bus.stage_en, 3'b111);
        chk("rst_stage_valid", bus.stage_valid, 3'b000);
        step(); rst = 0; #2;
        chk("post_rst_valid", bus.stage_valid, 3'b000);

        // add x5 then a reader of x5 on port 0
        issue(5, 0); step();
        reader(0, 5); #2;
`ifdef YSYX_22041412_FWD_EN
        chk("add_fwd0", bus.fwd_sel[1:0], 2'd1);
        chk("add_if_en", bus.if_en, 1'b1);
`else
        chk("add_fwd0", bus.fwd_sel[1:0], 2'd0);
        chk("add_if_en", bus.if_en, 1'b0);
`endif
        drain();

        // lw x6 then a reader of x6 on port 1: one load-use bubble
        issue(6, 1); step();
        reader(1, 6); #2;
        chk("lu_if_en", bus.if_en, 1'b0);
        chk("lu_id_en", bus.id_en, 1'b0);
        chk("lu_bubble_ex", bus.bubble_ex, 1'b1);
        step(); #2;
`ifdef YSYX_22041412_FWD_EN
        chk("lu_fwd1", bus.fwd_sel[3:2], 2'd2);
        chk("lu_if_en_after", bus.if_en, 1'b1);
`else
        chk("lu_if_en_after", bus.if_en, 1'b0);
`endif
        drain();

        // ex_busy for 4 cycles with a dependent add in ID
        issue(9, 0); step();
        reader(0, 9); bus.ex_busy = 1;
        for (int i = 0; i < 4; i++) begin
            #2;
            chk("busy_stage_en", bus.stage_en, 3'b110);
            chk("busy_if_en", bus.if_en, 1'b0);
            step();
        end
        bus.ex_busy = 0; #2;
        chk("busy_kept_ex", bus.stage_valid, 3'b001);
        drain();

        // redirect together with a load-use hazard
        issue(8, 1); step();
        reader(0, 8); bus.redirect = 1; #2;
        chk("redir_flush", bus.flush_id, 1'b1);
        chk("redir_bubble", bus.bubble_ex, 1'b1);
        chk("redir_if_en", bus.if_en, 1'b1);
        step(); quiet(); #2;
        chk("redir_ex_empty", bus.stage_valid[0], 1'b0);
        drain();

        // reset in the middle of a memory stall
        issue(3, 0); step();
        quiet(); bus.mem_busy = 1; #2;
        chk("mem_stage_en", bus.stage_en, 3'b100);
        step(); rst = 1; #2;
        chk("rstbusy_stage_en", bus.stage_en, 3'b111);
        chk("rstbusy_if_en", bus.if_en, 1'b1);
        step(); rst = 0; bus.mem_busy = 0; #2;
        chk("rstbusy_valid", bus.stage_valid, 3'b000);
        chk("rstbusy_en_after", bus.stage_en, 3'b111);
        chk("rstbusy_if_after", bus.if_en, 1'b1);
        drain();

        // add x7 then a dependent instruction
        issue(7, 0); step();
        reader(0, 7);
`ifdef YSYX_22041412_FWD_EN
        #2;
        chk("x7_fwd", bus.fwd_sel[1:0], 2'd1);
        chk("x7_if_en", bus.if_en, 1'b1);
`else
        for (int i = 0; i < 3; i++) begin
            #2;
            chk("x7_stall", bus.if_en, 1'b0);
            step();
        end
        #2;
        chk("x7_release", bus.if_en, 1'b1);
        chk("x7_fwd", bus.fwd_sel, 4'd0);
`endif
        drain();

        // random traffic over a small register range to provoke matches
        for (int i = 0; i < 600; i++) begin
            step();
            rst             = ($urandom_range(0, 99) < 2);
            bus.id_valid    = ($urandom_range(0, 9) < 8);
            bus.id_rs       = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
            bus.id_rs_used  = NRP'($urandom_range(0, 3));
            bus.id_rd       = AW'($urandom_range(0, 7));
            bus.id_rd_wen   = ($urandom_range(0, 9) < 7);
            bus.id_is_load  = ($urandom_range(0, 9) < 3);
            bus.ex_busy     = ($urandom_range(0, 9) < 1);
            bus.mem_busy    = ($urandom_range(0, 99) < 8);
            bus.redirect    = ($urandom_range(0, 99) < 8);
        end
        step();
        rst = 0;
        quiet();
        repeat (3) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
